// File: rtl/slow_adc_pkg.sv
// Shared constants, state encoding and helpers for the slow_adc SPI ADC sequencer.
package slow_adc_pkg;

    localparam int WORD_LEN = 16;
    localparam int ID_MSB   = 13;
    localparam int ID_LSB   = 12;
    localparam int SAMPLE_W = 12;
    localparam int CMD_W    = 4;
    localparam int ADDR_W   = 2;

    // Only the low ID_MSB+1 bits of a received word carry information.
    localparam int RX_W     = ID_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CS_SETUP = 2'd1,
        ST_SHIFT    = 2'd2,
        ST_CS_HOLD  = 2'd3
    } state_t;

    // Word index that follows idx in a round of n_ch words (wraps to 0).
    function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] idx,
                                                    input int n_ch);
        if (int'(idx) >= n_ch - 1) begin
            return '0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/slow_adc_sclk_gen.sv
// SCLK divider: free-running counter while i_run is high, giving a low-then-high
// serial clock and single-cycle strobes at the rising half and at period end.
module slow_adc_sclk_gen #(
    parameter int CLK_DIV = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CLK_DIV-1:0] HALF = CLK_DIV'(2 ** (CLK_DIV - 1));
    localparam logic [CLK_DIV-1:0] LAST = '1;

    logic [CLK_DIV-1:0] r_cnt;

    // Divider counter: held at zero outside SHIFT so every word starts on a fresh period.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_run) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // sclk is low for the first half of the period, high for the second.
    assign o_sclk = i_run & r_cnt[CLK_DIV-1];
    // o_rise marks the first high cycle of sclk (input sampling point).
    assign o_rise = i_run & (r_cnt == HALF);
    // o_fall marks the last cycle of a period: sclk drops at its closing edge.
    assign o_fall = i_run & (r_cnt == LAST);

endmodule

// File: rtl/slow_adc.sv
// slow_adc: sequences N_CH SPI conversions per round against a 12-bit multi-channel
// ADC, checks returned channel IDs and publishes all samples once per round.
module slow_adc
    import slow_adc_pkg::*;
#(
    parameter int CLK_DIV = 3,
    parameter int N_CH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CMD_W-1:0]      cmd,
    output logic                  cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [16*N_CH-1:0]    data,
    output logic                  data_valid,
    output logic                  ch_err
);

    localparam int                  BIT_CNT_W  = $clog2(WORD_LEN);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(WORD_LEN - 1);
    localparam logic [CLK_DIV-1:0]  SETUP_LAST = CLK_DIV'(2 ** (CLK_DIV - 1) - 1);
    localparam logic [CLK_DIV-1:0]  HOLD_LAST  = '1;
    localparam int                  PAD_W      = WORD_LEN - CMD_W - ADDR_W;
    localparam int                  ZEXT_W     = WORD_LEN - SAMPLE_W;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CLK_DIV-1:0]     r_tmr;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [ADDR_W-1:0]      r_word_idx;
    logic [WORD_LEN-1:0]    r_tx_sr;
    logic [RX_W-1:0]        r_rx_sr;
    logic [SAMPLE_W-1:0]    r_slot [N_CH];
    logic [16*N_CH-1:0]     r_data;
    logic                   r_data_valid;
    logic                   r_ch_err;

    logic                   w_sclk;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_word_end;
    logic                   w_setup_entry;
    logic [ADDR_W-1:0]      w_rx_id;
    logic [SAMPLE_W-1:0]    w_rx_sample;

    slow_adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_run  (r_state == ST_SHIFT),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_word_end    = (r_state == ST_SHIFT) && w_fall && (r_bit_cnt == BIT_LAST);
    assign w_setup_entry = (w_state_nxt == ST_CS_SETUP) && (r_state != ST_CS_SETUP);
    assign w_rx_id       = r_rx_sr[ID_MSB:ID_LSB];
    assign w_rx_sample   = r_rx_sr[SAMPLE_W-1:0];

    // FSM state register; reset forces IDLE even in the middle of a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; enable is only consulted in IDLE and at the end of CS_HOLD,
    // so a word in flight always completes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (r_tmr == SETUP_LAST) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_word_end) begin
                    w_state_nxt = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD: begin
                if (r_tmr == HOLD_LAST) begin
                    w_state_nxt = enable ? ST_CS_SETUP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: chip select and serial lines decoded from state.
    always_comb begin
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        case (r_state)
            ST_CS_SETUP: begin
                cs_n = 1'b0;
                mosi = r_tx_sr[WORD_LEN-1];
            end
            ST_SHIFT: begin
                cs_n = 1'b0;
                sclk = w_sclk;
                mosi = r_tx_sr[WORD_LEN-1];
            end
            default: begin
                cs_n = 1'b1;
            end
        endcase
    end

    // Dwell timer for CS_SETUP and CS_HOLD, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt != r_state)) begin
            r_tmr <= '0;
        end else if ((r_state == ST_CS_SETUP) || (r_state == ST_CS_HOLD)) begin
            r_tmr <= r_tmr + 1'b1;
        end else begin
            r_tmr <= '0;
        end
    end

    // Counts completed SCLK periods within the current word.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SHIFT)) begin
            r_bit_cnt <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Word index advances at each word end; leaving to IDLE restarts the round at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_idx <= '0;
        end else if (w_word_end) begin
            r_word_idx <= next_word(r_word_idx, N_CH);
        end else if ((r_state == ST_CS_HOLD) && (w_state_nxt == ST_IDLE)) begin
            r_word_idx <= '0;
        end
    end

    // Transmit shifter: loaded with the next channel address on CS_SETUP entry,
    // shifted as sclk falls so mosi is stable across each rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr <= '0;
        end else if (w_setup_entry) begin
            r_tx_sr <= {cmd, next_word(r_word_idx, N_CH), {PAD_W{1'b0}}};
        end else if ((r_state == ST_SHIFT) && w_fall) begin
            r_tx_sr <= {r_tx_sr[WORD_LEN-2:0], 1'b0};
        end
    end

    // Receive shifter: miso captured when sclk rises; the two top bits fall off the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_sr <= '0;
        end else if (w_rise) begin
            r_rx_sr <= {r_rx_sr[RX_W-2:0], miso};
        end
    end

    // Sample slots, ID check and round publication at each word end.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_slot[k] <= '0;
            end
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_ch_err     <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (w_word_end) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (k == int'(r_word_idx)) begin
                        r_slot[k] <= w_rx_sample;
                    end
                end
                if (w_rx_id != r_word_idx) begin
                    r_ch_err <= 1'b1;
                end
                if (int'(r_word_idx) == N_CH - 1) begin
                    for (int k = 0; k < N_CH; k++) begin
                        if (k == int'(r_word_idx)) begin
                            r_data[16*k +: 16] <= {{ZEXT_W{1'b0}}, w_rx_sample};
                        end else begin
                            r_data[16*k +: 16] <= {{ZEXT_W{1'b0}}, r_slot[k]};
                        end
                    end
                    r_data_valid <= 1'b1;
                end
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign ch_err     = r_ch_err;

endmodule

// File: tb/tb_slow_adc.sv
// Testbench for slow_adc: ADC model with response/expectation queues and a data monitor.
module tb_slow_adc;

    localparam int CLK_DIV = 3;
    localparam int N_CH    = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  cmd;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [63:0] data;
    logic        data_valid;
    logic        ch_err;

    typedef struct packed {
        logic [1:0]  id;
        logic [11:0] smp;
        logic        chk_gap;
    } resp_t;

    typedef struct packed {
        logic [15:0] word;
        logic        err;
    } exp_w_t;

    typedef struct packed {
        logic [63:0] dat;
        logic        err;
    } exp_d_t;

    resp_t  resp_q[$];
    exp_w_t exp_mosi_q[$];
    exp_d_t exp_data_q[$];

    int n_chk;
    int n_fail;
    int dv_count;
    int words_started;
    int edges_cur;
    bit abort_ok;

    slow_adc #(
        .CLK_DIV (CLK_DIV),
        .N_CH    (N_CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cmd        (cmd),
        .cs_n       (cs_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .data       (data),
        .data_valid (data_valid),
        .ch_err     (ch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic push_word(input logic [1:0] a_id, input logic [11:0] a_smp, input logic a_gap,
                             input logic [15:0] a_mosi, input logic a_err);
        resp_q.push_back('{id: a_id, smp: a_smp, chk_gap: a_gap});
        exp_mosi_q.push_back('{word: a_mosi, err: a_err});
    endtask

    task automatic wait_dv(input int target);
        int n = 0;
        while (dv_count < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("dv_wait", 64'(dv_count >= target), 64'd1);
    endtask

    task automatic wait_word_edge(input int word_no, input int edge_no);
        int n = 0;
        while (!(words_started == word_no && edges_cur == edge_no) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("edge_wait", 64'(words_started == word_no && edges_cur == edge_no), 64'd1);
    endtask

    // ADC model and serial-side scoreboard, sampling on the falling clk edge.
    initial begin : adc_model
        logic        prev_cs;
        logic        prev_sclk;
        logic [15:0] tx;
        logic [15:0] rx;
        resp_t       cur;
        exp_w_t      ew;
        int          cyc;
        int          t_fall;
        int          t_rise;
        int          t_csrise;
        prev_cs   = 1'b1;
        prev_sclk = 1'b0;
        tx        = '0;
        rx        = '0;
        cyc       = 0;
        t_fall    = 0;
        t_rise    = 0;
        t_csrise  = 0;
        miso      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_cs === 1'b1 && cs_n === 1'b0) begin
                words_started++;
                edges_cur = 0;
                rx = '0;
                if (resp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL resp_q: word %0d started with no response queued", words_started);
                    cur = '0;
                end else begin
                    cur = resp_q.pop_front();
                end
                if (cur.chk_gap) begin
                    chk("cs_high_gap", 64'(cyc - t_csrise), 64'd8);
                end
                tx     = {2'b00, cur.id, cur.smp};
                miso   = tx[15];
                t_fall = cyc;
            end
            if (prev_sclk === 1'b0 && sclk === 1'b1) begin
                edges_cur++;
                rx = {rx[14:0], mosi};
                if (edges_cur == 1) begin
                    chk("cs_to_sclk_rise", 64'(cyc - t_fall), 64'd8);
                end else begin
                    chk("sclk_period", 64'(cyc - t_rise), 64'd8);
                end
                t_rise = cyc;
            end
            if (prev_sclk === 1'b1 && sclk === 1'b0) begin
                tx   = {tx[14:0], 1'b0};
                miso = tx[15];
            end
            if (prev_cs === 1'b0 && cs_n === 1'b1) begin
                t_csrise = cyc;
                if (!abort_ok) begin
                    chk("sclk_edges", 64'(edges_cur), 64'd16);
                end
                if (edges_cur == 16) begin
                    if (exp_mosi_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL mosi_word: got 0x%0h with nothing expected", rx);
                    end else begin
                        ew = exp_mosi_q.pop_front();
                        chk("mosi_word", 64'(rx), 64'(ew.word));
                        chk("ch_err_word", 64'(ch_err), 64'(ew.err));
                    end
                end
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    // Parallel-side monitor: every data_valid pulse is matched against the queue.
    initial begin : data_monitor
        exp_d_t ed;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                dv_count++;
                if (exp_data_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL data_valid: unexpected pulse, data 0x%0h", data);
                end else begin
                    ed = exp_data_q.pop_front();
                    chk("data", data, ed.dat);
                    chk("dv_ch_err", 64'(ch_err), 64'(ed.err));
                end
            end
        end
    end

    initial begin : stimulus
        int base;
        n_chk         = 0;
        n_fail        = 0;
        dv_count      = 0;
        words_started = 0;
        edges_cur     = 0;
        abort_ok      = 1'b0;
        rst           = 1'b1;
        enable        = 1'b0;
        cmd           = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 64'(cs_n), 64'd1);
        chk("rst_sclk", 64'(sclk), 64'd0);
        chk("rst_mosi", 64'(mosi), 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_data_valid", 64'(data_valid), 64'd0);
        chk("rst_ch_err", 64'(ch_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal round, cmd A.
        cmd = 4'hA;
        push_word(2'd0, 12'h123, 1'b0, 16'hA400, 1'b0);
        push_word(2'd1, 12'h456, 1'b1, 16'hA800, 1'b0);
        push_word(2'd2, 12'h789, 1'b1, 16'hAC00, 1'b0);
        push_word(2'd3, 12'hABC, 1'b1, 16'hA000, 1'b0);
        exp_data_q.push_back('{dat: 64'h0ABC_0789_0456_0123, err: 1'b0});
        enable = 1'b1;
        wait_dv(1);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("idle_cs_n", 64'(cs_n), 64'd1);
        chk("idle_words", 64'(words_started), 64'd4);
        chk("hold_data_a", data, 64'h0ABC_0789_0456_0123);

        // Wrong channel ID in word 1: sticky error.
        cmd = 4'h5;
        push_word(2'd0, 12'h111, 1'b0, 16'h5400, 1'b0);
        push_word(2'd2, 12'h222, 1'b1, 16'h5800, 1'b1);
        push_word(2'd2, 12'h333, 1'b1, 16'h5C00, 1'b1);
        push_word(2'd3, 12'h444, 1'b1, 16'h5000, 1'b1);
        exp_data_q.push_back('{dat: 64'h0444_0333_0222_0111, err: 1'b1});
        enable = 1'b1;
        wait_dv(2);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk("ch_err_sticky", 64'(ch_err), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("ch_err_cleared", 64'(ch_err), 64'd0);
        chk("data_cleared", data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full round, then enable dropped at sclk edge 5 of word 2, then restart.
        cmd = 4'h3;
        push_word(2'd0, 12'h0F1, 1'b0, 16'h3400, 1'b0);
        push_word(2'd1, 12'h0F2, 1'b1, 16'h3800, 1'b0);
        push_word(2'd2, 12'h0F3, 1'b1, 16'h3C00, 1'b0);
        push_word(2'd3, 12'h0F4, 1'b1, 16'h3000, 1'b0);
        exp_data_q.push_back('{dat: 64'h00F4_00F3_00F2_00F1, err: 1'b0});
        push_word(2'd0, 12'h5A1, 1'b1, 16'h3400, 1'b0);
        push_word(2'd1, 12'h5A2, 1'b1, 16'h3800, 1'b0);
        push_word(2'd2, 12'h5A3, 1'b1, 16'h3C00, 1'b0);
        base   = words_started;
        enable = 1'b1;
        wait_word_edge(base + 7, 5);
        enable = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_cs_n", 64'(cs_n), 64'd1);
        chk("abort_data_kept", data, 64'h00F4_00F3_00F2_00F1);
        chk("abort_dv_count", 64'(dv_count), 64'd3);
        chk("abort_words", 64'(words_started - base), 64'd7);
        push_word(2'd0, 12'h701, 1'b0, 16'h3400, 1'b0);
        push_word(2'd1, 12'h702, 1'b1, 16'h3800, 1'b0);
        push_word(2'd2, 12'h703, 1'b1, 16'h3C00, 1'b0);
        push_word(2'd3, 12'h704, 1'b1, 16'h3000, 1'b0);
        exp_data_q.push_back('{dat: 64'h0704_0703_0702_0701, err: 1'b0});
        enable = 1'b1;
        wait_dv(4);
        enable = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of SHIFT with enable held high.
        cmd      = 4'hC;
        abort_ok = 1'b1;
        resp_q.push_back('{id: 2'd0, smp: 12'h999, chk_gap: 1'b0});
        base   = words_started;
        enable = 1'b1;
        wait_word_edge(base + 1, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cs_n", 64'(cs_n), 64'd1);
        chk("midrst_sclk", 64'(sclk), 64'd0);
        chk("midrst_mosi", 64'(mosi), 64'd0);
        chk("midrst_data", data, 64'd0);
        chk("midrst_data_valid", 64'(data_valid), 64'd0);
        rst = 1'b0;
        push_word(2'd0, 12'h0C1, 1'b0, 16'hC400, 1'b0);
        push_word(2'd1, 12'h0C2, 1'b1, 16'hC800, 1'b0);
        push_word(2'd2, 12'h0C3, 1'b1, 16'hCC00, 1'b0);
        push_word(2'd3, 12'h0C4, 1'b1, 16'hC000, 1'b0);
        exp_data_q.push_back('{dat: 64'h00C4_00C3_00C2_00C1, err: 1'b0});
        repeat (3) @(negedge clk);
        abort_ok = 1'b0;
        wait_dv(5);
        enable = 1'b0;
        repeat (40) @(negedge clk);

        chk("final_dv_count", 64'(dv_count), 64'd5);
        chk("final_resp_q", 64'(resp_q.size()), 64'd0);
        chk("final_mosi_q", 64'(exp_mosi_q.size()), 64'd0);
        chk("final_data_q", 64'(exp_data_q.size()), 64'd0);
        chk("final_ch_err", 64'(ch_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/slow_adc.md
SLOW_ADC -- requirements
Module: slow_adc

Interface
REQ-001 SHALL have parameter CLK_DIV, default 3; SCLK period = 2**CLK_DIV clk cycles, CLK_DIV >= 2.
REQ-002 SHALL have parameter N_CH, default 4; channels per round, 1..4.
REQ-003 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: level; high requests continuous conversion rounds.
REQ-006 SHALL have port cmd, input, 4: command nibble sent in MOSI bits 15:12 of every word.
REQ-007 SHALL have port cs_n, output, 1: ADC chip select, active low.
REQ-008 SHALL have port sclk, output, 1: serial clock, idle low.
REQ-009 SHALL have port mosi, output, 1: control word to ADC, MSB first.
REQ-010 SHALL have port miso, input, 1: ADC data, MSB first.
REQ-011 SHALL have port data, output, 16*N_CH: channel k in bits 16k+15:16k, 12-bit sample zero-extended.
REQ-012 SHALL have port data_valid, output, 1: one-cycle pulse when data updates.
REQ-013 SHALL have port ch_err, output, 1: sticky; set when returned channel ID mismatches expected ID.

Function
REQ-014 SHALL implement FSM IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> (CS_SETUP | IDLE).
REQ-015 In IDLE with enable=1, SHALL enter CS_SETUP next cycle; cs_n SHALL go low that same cycle.
REQ-016 CS_SETUP SHALL last 2**(CLK_DIV-1) cycles, sclk low, mosi = word bit 15.
REQ-017 SHIFT SHALL produce exactly 16 SCLK periods: sclk low for first half, high for second half of each period.
REQ-018 mosi SHALL change only in the cycle sclk falls (or CS_SETUP entry); miso SHALL be registered in the cycle sclk rises.
REQ-019 Word w (0..N_CH-1) MOSI SHALL be {cmd, ADDR[1:0], 10'b0}, where ADDR = (w+1) mod N_CH, the channel for the next conversion.
REQ-020 Received word SHALL be decoded as bits 15:14 ignored, 13:12 channel ID, 11:0 sample.
REQ-021 Sample from word w SHALL be stored in slot w; ch_err SHALL set if ID != w.
REQ-022 CS_HOLD SHALL drive cs_n high, sclk low, for 2**CLK_DIV cycles.
REQ-023 After word N_CH-1, all slots SHALL be copied to data in the cycle CS_HOLD is entered, with data_valid high for that one cycle.
REQ-024 From CS_HOLD, SHALL go to CS_SETUP if enable=1 at its last cycle, else IDLE; word index SHALL wrap N_CH-1 -> 0.
REQ-025 enable falling mid-word SHALL NOT abort the word; after it completes, FSM SHALL go to IDLE, partial round discarded, data unchanged, word index reset to 0.
REQ-026 data SHALL hold its last value between updates.
REQ-027 ch_err SHALL clear only on rst.

Reset
REQ-028 On rst=1, SHALL enter IDLE next cycle regardless of state, including mid-word.
REQ-029 Reset values SHALL be cs_n=1, sclk=0, mosi=0, data=0, data_valid=0, ch_err=0, counters and word index 0.

Structure
REQ-030 A shared package/header SHALL define WORD_LEN=16, ID_MSB=13, ID_LSB=12, SAMPLE_W=12, and state encodings.
REQ-031 A single sub-module slow_adc_sclk_gen (divider counter, rise/fall strobes) SHALL be used; shift registers and FSM stay in slow_adc.

Verification
REQ-032 CLK_DIV=3, N_CH=4, ADC model returns ID=w with samples 0x123, 0x456, 0x789, 0xABC -> data=0x0ABC_0789_0456_0123, one data_valid pulse, ch_err=0.
REQ-033 cmd=4'hA -> MOSI words 0xA400, 0xA800, 0xAC00, 0xA000 captured on sclk rising edges; 16 sclk edges per cs_n low window.
REQ-034 Timing check -> cs_n low-to-first-sclk-rise = 8 clk cycles, sclk period 8 cycles, cs_n high gap = 8 cycles.
REQ-035 Model returns ID=2 in word 1 -> ch_err=1 after word 1 and stays 1 until rst.
REQ-036 enable dropped at sclk edge 5 of word 2 -> word 2 completes, FSM reaches IDLE, no data_valid, data unchanged; re-enable -> round restarts at word 0.
REQ-037 rst asserted mid-SHIFT -> next cycle cs_n=1, sclk=0, data=0; with enable=1 held, new round starts with word 0.
